i2c_req_arbiter: RTL and testbench

- Round-robin arbiter and transaction sequencer placed in front of the single I2C master engine.
- Arbitrates NREQ client requests and latches the winner's command, then drives the master's start/addr/rw/N_byte/data_w inputs.
- Tracks the master's busy/error/valid handshake and returns read bytes, completion and error to the granted client only.

---
 rtl/i2c_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter and transaction sequencer in front of a single I2C master.
// Latches the winning client's command, launches the master and routes results back.
module i2c_req_arbiter #(
  parameter int NREQ     = 4,
  parameter int START_TO = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [4*NREQ-1:0] req_nbyte,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        rd_data,
  output logic [NREQ-1:0]   rd_valid,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              m_start,
  output logic [6:0]        m_addr,
  output logic              m_rw,
  output logic [3:0]        m_nbyte,
  output logic [7:0]        m_data_w,
  input  logic              m_busy,
  input  logic              m_erro_addr,
  input  logic [7:0]        m_data_out,
  input  logic              m_valid_out
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(START_TO + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, ACTIVE, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gidx;
  logic [TW-1:0]   timer;
  logic            err_lat;

  logic            hi_found;
  logic [IW-1:0]   hi_idx;
  logic [IW-1:0]   lo_idx;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [6:0]      win_addr;
  logic            win_rw;
  logic [3:0]      win_nbyte;

  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IW'(i);
        if (IW'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    win_onehot = '0;
    win_addr   = '0;
    win_rw     = 1'b0;
    win_nbyte  = '0;
    m_data_w   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_onehot[i] = 1'b1;
        win_addr      = req_addr[7*i +: 7];
        win_rw        = req_rw[i];
        win_nbyte     = req_nbyte[4*i +: 4];
      end
      if (gnt[i]) begin
        m_data_w = req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gidx     <= '0;
      gnt      <= '0;
      rd_valid <= '0;
      done     <= '0;
      err      <= '0;
      rd_data  <= '0;
      m_start  <= 1'b0;
      m_addr   <= '0;
      m_rw     <= 1'b0;
      m_nbyte  <= '0;
      timer    <= '0;
      err_lat  <= 1'b0;
    end else begin
      m_start  <= 1'b0;
      rd_valid <= '0;
      done     <= '0;
      err      <= '0;
      case (state)
        IDLE: begin
          if (|req && !m_busy) begin
            gidx    <= win_idx;
            gnt     <= win_onehot;
            m_addr  <= win_addr;
            m_rw    <= win_rw;
            m_nbyte <= win_nbyte;
            m_start <= 1'b1;
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer   <= '0;
          err_lat <= 1'b0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (m_busy) begin
            state <= ACTIVE;
          end else if (timer == TW'(START_TO - 1)) begin
            err_lat <= 1'b1;
            done    <= gnt;
            err     <= gnt;
            state   <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ACTIVE: begin
          if (m_valid_out) begin
            rd_data  <= m_data_out;
            rd_valid <= gnt;
          end
          if (m_erro_addr) begin
            err_lat <= 1'b1;
          end
          // An address NACK arriving with the busy fall still counts for this transaction.
          if (!m_busy) begin
            done  <= gnt;
            err   <= (err_lat || m_erro_addr) ? gnt : '0;
            state <= DONE;
          end
        end
        DONE: begin
          gnt    <= '0;
          rr_ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized bench for i2c_req_arbiter: plays the clients and the I2C master and
// predicts grants, launches, read bytes and completions from a transaction-level model.
module tb_i2c_req_arbiter;

  localparam int NREQ     = 4;
  localparam int START_TO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [7*NREQ-1:0] req_addr = '0;
  logic [NREQ-1:0]   req_rw = '0;
  logic [4*NREQ-1:0] req_nbyte = '0;
  logic [8*NREQ-1:0] req_wdata = '0;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        rd_data;
  logic [NREQ-1:0]   rd_valid;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   err;
  logic              m_start;
  logic [6:0]        m_addr;
  logic              m_rw;
  logic [3:0]        m_nbyte;
  logic [7:0]        m_data_w;
  logic              m_busy = 1'b0;
  logic              m_erro_addr = 1'b0;
  logic [7:0]        m_data_out = '0;
  logic              m_valid_out = 1'b0;

  always #5 clk = ~clk;

  i2c_req_arbiter #(.NREQ(NREQ), .START_TO(START_TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_nbyte(req_nbyte), .req_wdata(req_wdata), .gnt(gnt), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done), .err(err), .m_start(m_start), .m_addr(m_addr),
    .m_rw(m_rw), .m_nbyte(m_nbyte), .m_data_w(m_data_w), .m_busy(m_busy),
    .m_erro_addr(m_erro_addr), .m_data_out(m_data_out), .m_valid_out(m_valid_out)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model state: round-robin pointer, current winner, pending read byte.
  int              rr_model = 0;
  int              g_win = 0;
  bit              exp_err = 1'b0;
  bit              pend_v = 1'b0;
  logic [7:0]      pend_d = '0;
  logic [7:0]      last_rd = '0;
  logic [6:0]      c_addr [NREQ];
  logic            c_rw   [NREQ];
  logic [3:0]      c_nb   [NREQ];
  logic [7:0]      c_wd   [NREQ];
  logic [NREQ-1:0] cur_req = '0;

  function automatic logic [31:0] oh(input int i);
    return 32'd1 << i;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    compared++;
    if (got !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] reqv, input bit rnd);
    for (int i = 0; i < NREQ; i++) begin
      if (rnd) begin
        c_addr[i] = 7'($urandom);
        c_rw[i]   = 1'($urandom);
        c_nb[i]   = 4'($urandom);
        c_wd[i]   = 8'($urandom);
      end
      req_addr[7*i +: 7]  = c_addr[i];
      req_rw[i]           = c_rw[i];
      req_nbyte[4*i +: 4] = c_nb[i];
      req_wdata[8*i +: 8] = c_wd[i];
    end
    cur_req = reqv;
    req     = reqv;
  endtask

  task automatic checkCycle(input bit exp_done);
    checkOutput("rd_valid", rd_valid, pend_v ? oh(g_win) : 32'd0);
    if (pend_v) last_rd = pend_d;
    pend_v = 1'b0;
    checkOutput("rd_data", rd_data, last_rd);
    checkOutput("done", done, exp_done ? oh(g_win) : 32'd0);
    checkOutput("err", err, (exp_done && exp_err) ? oh(g_win) : 32'd0);
    checkOutput("m_start_once", m_start, 0);
  endtask

  // One full transaction: d = busy-rise delay after m_start, len = ACTIVE cycles,
  // tmo = master never responds, emode 0 none / 1 random / 2 forced NACK.
  task automatic runTxn(input int d, input int len, input bit tmo, input int emode,
                        input bit v_on, input logic [NREQ-1:0] next_req);
    int n;
    int idx;
    logic [6:0] e_addr;
    logic e_rw;
    logic [3:0] e_nb;
    bit dv;
    g_win = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (rr_model + k) % NREQ;
      if (g_win < 0 && ((cur_req >> idx) & 1) != 0) g_win = idx;
    end
    if (g_win < 0) g_win = 0;
    exp_err = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_start && n < 12);
    checkOutput("launch", m_start, 1);
    checkOutput("gnt", gnt, oh(g_win));
    checkOutput("m_addr", m_addr, c_addr[g_win]);
    checkOutput("m_rw", m_rw, c_rw[g_win]);
    checkOutput("m_nbyte", m_nbyte, c_nb[g_win]);
    checkOutput("m_data_w", m_data_w, c_wd[g_win]);
    e_addr = c_addr[g_win];
    e_rw   = c_rw[g_win];
    e_nb   = c_nb[g_win];
    applyStimulus(next_req, 1'b1);
    if (tmo) begin
      for (int c = 1; c <= START_TO; c++) begin
        @(negedge clk);
        checkCycle(1'b0);
      end
      @(negedge clk);
      exp_err = 1'b1;
      checkCycle(1'b1);
    end else begin
      for (int c = 1; c <= d; c++) begin
        @(negedge clk);
        checkCycle(1'b0);
        if (c == 1) begin
          checkOutput("m_data_w_live", m_data_w, c_wd[g_win]);
          checkOutput("m_addr_latched", m_addr, e_addr);
          checkOutput("m_rw_latched", m_rw, e_rw);
          checkOutput("m_nbyte_latched", m_nbyte, e_nb);
        end
        if (c == d) m_busy = 1'b1;
      end
      for (int j = 0; j < len; j++) begin
        @(negedge clk);
        checkCycle(1'b0);
        dv = v_on && ($urandom_range(0, 1) == 1);
        m_valid_out = dv;
        m_data_out  = 8'($urandom);
        if (dv) begin
          pend_v = 1'b1;
          pend_d = m_data_out;
        end
        m_erro_addr = (emode == 2 && j == 0) || (emode == 1 && $urandom_range(0, 5) == 0);
        if (m_erro_addr) exp_err = 1'b1;
        m_busy = (j < len - 1);
      end
      @(negedge clk);
      checkCycle(1'b1);
      m_valid_out = 1'b0;
      m_erro_addr = 1'b0;
    end
    rr_model = (g_win + 1) % NREQ;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NREQ-1:0] rq;
    applyStimulus('0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_m_start", m_start, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_m_addr", m_addr, 0);
    checkOutput("rst_m_data_w", m_data_w, 0);
    rst_n = 1'b1;
    @(negedge clk);

    c_addr[0] = 7'h50;
    c_rw[0]   = 1'b0;
    c_nb[0]   = 4'd2;
    applyStimulus(4'b0001, 1'b0);
    runTxn(1, 40, 1'b0, 0, 1'b0, 4'b1111);

    for (int i = 0; i < 5; i++) begin
      runTxn($urandom_range(1, 3), $urandom_range(1, 5), 1'b0, 0, 1'b1,
             (i < 4) ? 4'b1111 : 4'b0000);
    end

    $display("[TB] no grant while master busy, withdrawn request");
    @(negedge clk);
    m_busy = 1'b1;
    applyStimulus(4'b1000, 1'b1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("busy_block_gnt", gnt, 0);
      checkOutput("busy_block_start", m_start, 0);
    end
    applyStimulus(4'b0000, 1'b1);
    m_busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("withdraw_gnt", gnt, 0);
    end
    applyStimulus(4'b0110, 1'b1);
    runTxn(1, 5, 1'b0, 1, 1'b1, 4'b0000);

    $display("[TB] launch timeout and address NACK");
    @(negedge clk);
    applyStimulus(4'b0100, 1'b1);
    runTxn(1, 1, 1'b1, 0, 1'b0, 4'b0001);
    runTxn(2, 4, 1'b0, 2, 1'b1, 4'b0000);

    $display("[TB] randomized transactions");
    @(negedge clk);
    applyStimulus(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'b1);
    for (int t = 0; t < 40; t++) begin
      rq = (t == 39) ? '0 : NREQ'($urandom_range(1, (1 << NREQ) - 1));
      runTxn($urandom_range(1, 4), $urandom_range(1, 8), $urandom_range(0, 9) == 0,
             $urandom_range(0, 1), 1'b1, rq);
    end

    $display("[TB] reset during ACTIVE");
    @(negedge clk);
    applyStimulus(4'b0100, 1'b1);
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!m_start && n < 12);
      checkOutput("mid_launch", m_start, 1);
    end
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    m_busy = 1'b1;
    @(negedge clk);
    m_valid_out = 1'b1;
    m_data_out  = 8'h77;
    @(negedge clk);
    m_valid_out = 1'b0;
    checkOutput("mid_rd_valid", rd_valid, 4'b0100);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_gnt", gnt, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_err", err, 0);
    checkOutput("mid_rst_rd_valid", rd_valid, 0);
    checkOutput("mid_rst_m_start", m_start, 0);
    checkOutput("mid_rst_rd_data", rd_data, 0);
    m_busy = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    rr_model = 0;
    last_rd  = '0;
    pend_v   = 1'b0;
    applyStimulus(4'b1010, 1'b1);
    runTxn(1, 3, 1'b0, 0, 1'b1, 4'b0000);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
